// File: rtl/cdc_rst_gen.sv
// Reset sequencer for another clock domain: issues a held reset request and closes the
// handshake on the synchronized echo. Define CDC_RST_GEN_TIMEOUT_EN to abort stalled ack phases.
module cdc_rst_gen #(
  parameter int STAGES      = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int TIMEOUT     = 256
) (
  input  logic clk,
  input  logic i_rst,
  input  logic i_req,
  input  logic i_rst_ack,
  output logic o_rst_req,
  output logic o_busy,
  output logic o_done,
  output logic o_timeout
);

  localparam int MAX_CNT = (HOLD_CYCLES > TIMEOUT) ? HOLD_CYCLES : TIMEOUT;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX   = '1;
`ifdef CDC_RST_GEN_TIMEOUT_EN
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);
`endif

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ASSERT   = 2'd1,
    WAIT_ACK = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            rst_req_reg, rst_req_next;
  logic            done_reg, done_next;
`ifdef CDC_RST_GEN_TIMEOUT_EN
  logic            timeout_reg, timeout_next;
`endif

  // Ack echo synchronizer; only the last stage is trusted by the FSM.
  logic sync_reg [STAGES];
  logic sync_d   [STAGES];
  logic ack_s;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_head
        assign sync_d[gi] = i_rst_ack;
      end else begin : g_tail
        assign sync_d[gi] = sync_reg[gi-1];
      end
      always_ff @(posedge clk) begin
        if (i_rst) sync_reg[gi] <= 1'b0;
        else       sync_reg[gi] <= sync_d[gi];
      end
    end
  endgenerate

  assign ack_s = sync_reg[STAGES-1];

  always_comb begin
    state_next = state_reg;
    done_next  = 1'b0;
`ifdef CDC_RST_GEN_TIMEOUT_EN
    timeout_next = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (i_req) state_next = ASSERT;
      end
      ASSERT: begin
        if (cnt_reg == HOLD_LAST) state_next = ack_s ? WAIT_REL : WAIT_ACK;
      end
      WAIT_ACK: begin
        if (ack_s) state_next = WAIT_REL;
`ifdef CDC_RST_GEN_TIMEOUT_EN
        else if (cnt_reg == TIMEOUT_LAST) begin
          state_next   = IDLE;
          timeout_next = 1'b1;
        end
`endif
      end
      WAIT_REL: begin
        // A completed handshake wins over a timeout landing on the same cycle.
        if (!ack_s) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
`ifdef CDC_RST_GEN_TIMEOUT_EN
        else if (cnt_reg == TIMEOUT_LAST) begin
          state_next   = IDLE;
          timeout_next = 1'b1;
        end
`endif
      end
      default: state_next = IDLE;
    endcase

    if (state_next != state_reg) cnt_next = '0;
    else if (cnt_reg == CNT_MAX) cnt_next = cnt_reg;
    else                         cnt_next = cnt_reg + CW'(1);

    rst_req_next = (state_next == ASSERT) || (state_next == WAIT_ACK);
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_reg   <= ASSERT;
      cnt_reg     <= '0;
      rst_req_reg <= 1'b1;
      done_reg    <= 1'b0;
`ifdef CDC_RST_GEN_TIMEOUT_EN
      timeout_reg <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      rst_req_reg <= rst_req_next;
      done_reg    <= done_next;
`ifdef CDC_RST_GEN_TIMEOUT_EN
      timeout_reg <= timeout_next;
`endif
    end
  end

  assign o_rst_req = rst_req_reg;
  assign o_busy    = (state_reg != IDLE);
  assign o_done    = done_reg;
`ifdef CDC_RST_GEN_TIMEOUT_EN
  assign o_timeout = timeout_reg;
`else
  assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_rst_gen.sv
// Bench for cdc_rst_gen: directed handshake scenarios plus random traffic, all outputs
// checked every cycle against a phase/elapsed-time model of the sequencer.
module tb_cdc_rst_gen;

  localparam int STAGES = 2;
  localparam int HOLD   = 16;
  localparam int TMO    = 64;
`ifdef CDC_RST_GEN_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int P_IDLE = 0, P_HOLD = 1, P_WACK = 2, P_WREL = 3;

  logic clk;
  logic i_rst, i_req, i_rst_ack;
  logic o_rst_req, o_busy, o_done, o_timeout;

  int n_cmp  = 0;
  int n_fail = 0;
  int ack_mode;  // 0 loopback (3-cycle delay), 1 tied 0, 2 tied 1, 3 random

  cdc_rst_gen #(.STAGES(STAGES), .HOLD_CYCLES(HOLD), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .i_rst     (i_rst),
    .i_req     (i_req),
    .i_rst_ack (i_rst_ack),
    .o_rst_req (o_rst_req),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_timeout (o_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Destination-domain stand-in: echo of o_rst_req three cycles late, or forced values.
  initial begin : ack_drv
    bit [3:0] lb;
    lb = '0;
    i_rst_ack = 1'b0;
    forever begin
      @(negedge clk);
      lb = {lb[2:0], o_rst_req};
      case (ack_mode)
        0:       i_rst_ack = lb[3];
        1:       i_rst_ack = 1'b0;
        2:       i_rst_ack = 1'b1;
        default: i_rst_ack = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Reference: current phase plus the edge it was entered on; ack seen through a STAGES-deep queue.
  initial begin : model
    int  k, ent, ph, el;
    bit  acks, armed, e_done, e_to;
    bit  q[$];
    k = 0; ent = 0; ph = P_HOLD; armed = 1'b0;
    for (int i = 0; i < STAGES; i++) q.push_back(1'b0);
    forever begin
      @(posedge clk);
      k++;
      acks   = q[STAGES-1];
      e_done = 1'b0;
      e_to   = 1'b0;
      if (i_rst) begin
        ph = P_HOLD; ent = k; armed = 1'b1;
        for (int i = 0; i < STAGES; i++) q[i] = 1'b0;
      end else begin
        el = k - ent;
        case (ph)
          P_IDLE: if (i_req) begin ph = P_HOLD; ent = k; end
          P_HOLD: if (el == HOLD) begin ph = acks ? P_WREL : P_WACK; ent = k; end
          P_WACK: begin
            if (acks) begin ph = P_WREL; ent = k; end
            else if (TO_EN && el == TMO) begin ph = P_IDLE; ent = k; e_to = 1'b1; end
          end
          default: begin
            if (!acks) begin ph = P_IDLE; ent = k; e_done = 1'b1; end
            else if (TO_EN && el == TMO) begin ph = P_IDLE; ent = k; e_to = 1'b1; end
          end
        endcase
        q.push_front(i_rst_ack);
        void'(q.pop_back());
      end
      #1;
      if (armed) begin
        chk("m_rst_req", o_rst_req, int'(ph == P_HOLD || ph == P_WACK));
        chk("m_busy", o_busy, int'(ph != P_IDLE));
        chk("m_done", o_done, e_done);
        chk("m_timeout", o_timeout, e_to);
      end
    end
  end

  task automatic do_req();
    i_req = 1'b1;
    tick();
    i_req = 1'b0;
  endtask

  // Counts consecutive cycles with o_rst_req high, optionally pulsing i_req or i_req+i_rst
  // on the given (0-based) high cycle.
  task automatic run_high(input int req_at, input int both_at, output int hi);
    hi = 0;
    while (o_rst_req && hi < 400) begin
      i_req = (hi == req_at) || (hi == both_at);
      i_rst = (hi == both_at);
      hi++;
      tick();
    end
    i_req = 1'b0;
    i_rst = 1'b0;
  endtask

  task automatic wait_done(output int g);
    g = 0;
    while (!o_done && g < 100) begin
      tick();
      g++;
    end
  endtask

  initial begin : stim
    int hi, g, nd;
    i_rst = 1'b1; i_req = 1'b0; ack_mode = 0;

    repeat (4) begin
      tick();
      chk("por_rst_req", o_rst_req, 1);
      chk("por_busy", o_busy, 1);
      chk("por_done", o_done, 0);
      chk("por_timeout", o_timeout, 0);
    end
    i_rst = 1'b0;
    run_high(-1, -1, hi);
    chk("por_high", hi, 16);
    wait_done(g);
    chk("por_done_gap", g, 6);
    nd = 0;
    repeat (10) begin tick(); nd += int'(o_done); end
    chk("por_extra_done", nd, 0);
    chk("por_idle", o_busy, 0);
    $display("txn power-on: high=%0d done_gap=%0d", hi, g);

    do_req();
    chk("req_rise", o_rst_req, 1);
    run_high(-1, -1, hi);
    chk("req_high", hi, 16);
    wait_done(g);
    chk("req_done_gap", g, 6);
    tick();
    chk("req_idle", o_busy, 0);
    $display("txn request: high=%0d done_gap=%0d", hi, g);

    do_req();
    run_high(5, -1, hi);
    chk("coll_high", hi, 16);
    wait_done(g);
    chk("coll_done_gap", g, 6);
    nd = 0;
    repeat (20) begin tick(); nd += int'(o_done); end
    chk("coll_extra_done", nd, 0);
    chk("coll_idle", o_busy, 0);
    $display("txn req-in-assert: high=%0d done_gap=%0d", hi, g);

    do_req();
    run_high(-1, 8, hi);
    chk("rstreq_high", hi, 25);
    wait_done(g);
    chk("rstreq_done_gap", g, 6);
    tick();
    chk("rstreq_idle", o_busy, 0);
    $display("txn rst+req: high=%0d done_gap=%0d", hi, g);

    do_req();
    run_high(-1, -1, hi);
    chk("mid_in_wait_rel", o_busy, 1);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    chk("mid_rst_req", o_rst_req, 1);
    chk("mid_busy", o_busy, 1);
    chk("mid_done", o_done, 0);
    run_high(-1, -1, hi);
    chk("mid_high", hi, 16);
    wait_done(g);
    chk("mid_done_gap", g, 6);
    $display("txn mid-reset: high=%0d done_gap=%0d", hi, g);

    ack_mode = 1;
    repeat (8) tick();
    do_req();
`ifdef CDC_RST_GEN_TIMEOUT_EN
    run_high(-1, -1, hi);
    chk("to_high", hi, HOLD + TMO);
    chk("to_pulse", o_timeout, 1);
    chk("to_no_done", o_done, 0);
    chk("to_idle", o_busy, 0);
    tick();
    chk("to_pulse_end", o_timeout, 0);
    ack_mode = 0;
    $display("txn timeout: high=%0d", hi);
`else
    repeat (1000) begin
      chk("noack_rst_req", o_rst_req, 1);
      chk("noack_timeout", o_timeout, 0);
      tick();
    end
    chk("noack_busy", o_busy, 1);
    ack_mode = 0;
    wait_done(g);
    chk("noack_recover", int'(g < 100), 1);
    $display("txn no-ack wait: recovered after %0d cycles", g);
`endif
    repeat (4) tick();
    chk("noack_idle", o_busy, 0);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 63) == 0) ack_mode = int'($urandom_range(0, 3));
      i_req = ($urandom_range(0, 5) == 0);
      i_rst = ($urandom_range(0, 149) == 0);
      tick();
    end
    i_req = 1'b0; i_rst = 1'b1; ack_mode = 0;
    tick();
    i_rst = 1'b0;
    g = 0;
    while (o_busy && g < 200) begin tick(); g++; end
    chk("final_idle", o_busy, 0);
    $display("txn random: 3000 cycles, drained in %0d", g);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
